scroll_ctrl: RTL and testbench

//  Sequencer for the 8x8 dot-matrix row scanner: produces the 7-bit start index (idx) the

---
 rtl/scroll_ctrl.sv | 105 ++++++++++
 tb/tb_scroll_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl.sv
// Scroll sequencer for the 8x8 dot-matrix scanner: steps the column start index
// through a message on frame boundaries, in wrap or bounce mode with end dwell.
module scroll_ctrl #(
  parameter int IDX_W       = 7,
  parameter int SPD_W       = 4,
  parameter int HOLD_FRAMES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frame_sync,
  input  logic [SPD_W-1:0] speed,
  input  logic             dir,
  input  logic             mode,
  input  logic [IDX_W-1:0] msg_len,
  output logic [IDX_W-1:0] idx,
  output logic             at_end,
  output logic             wrap_pulse,
  output logic [1:0]       state
);

  localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} st_e;

  st_e              st;
  logic             eff_dir;
  logic [SPD_W-1:0] frame_cnt;
  logic [HC_W-1:0]  hold_cnt;
  logic [IDX_W-1:0] max_idx;

  always_comb begin
    max_idx = '0;
    if (msg_len > IDX_W'(8)) max_idx = msg_len - IDX_W'(8);
  end

  assign at_end = eff_dir ? (idx == '0) : (idx == max_idx);
  assign state  = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      idx        <= '0;
      eff_dir    <= 1'b0;
      frame_cnt  <= '0;
      hold_cnt   <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (!en) begin
        st        <= IDLE;
        frame_cnt <= '0;
        hold_cnt  <= '0;
      end else begin
        case (st)
          IDLE: begin
            st        <= RUN;
            eff_dir   <= dir;
            frame_cnt <= '0;
          end
          RUN: if (frame_sync) begin
            // a shrunk message pulls idx back before any stepping resumes
            if (idx > max_idx) idx <= max_idx;
            else if (frame_cnt >= speed) begin
              frame_cnt <= '0;
              if (max_idx != '0) begin
                if (at_end) begin
                  st       <= HOLD;
                  hold_cnt <= '0;
                end else begin
                  idx <= eff_dir ? idx - IDX_W'(1) : idx + IDX_W'(1);
                end
              end
            end else begin
              frame_cnt <= frame_cnt + SPD_W'(1);
            end
          end
          HOLD: if (frame_sync) begin
            if (idx > max_idx) idx <= max_idx;
            else if (max_idx == '0) begin
              st        <= RUN;
              frame_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              st         <= RUN;
              frame_cnt  <= '0;
              wrap_pulse <= 1'b1;
              if (mode) begin
                // reverse: leave the end we dwelt at by one column
                eff_dir <= ~eff_dir;
                idx     <= eff_dir ? IDX_W'(1) : max_idx - IDX_W'(1);
              end else begin
                idx <= eff_dir ? max_idx : '0;
              end
            end else begin
              hold_cnt <= hold_cnt + HC_W'(1);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: directed frame_sync sequences, a behavioural model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_scroll_ctrl;
  localparam int HF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       dir = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] msg_len = 7'd12;
  logic [6:0] idx;
  logic       at_end;
  logic       wrap_pulse;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int pulse_seen = 0;
  bit track_pulse = 0;

  scroll_ctrl #(.IDX_W(7), .SPD_W(4), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_sync(frame_sync), .speed(speed),
    .dir(dir), .mode(mode), .msg_len(msg_len), .idx(idx), .at_end(at_end),
    .wrap_pulse(wrap_pulse), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int idx;
    int st;    // 0 idle, 1 run, 2 hold
    int dir;
    int fc;    // frames waited since last step
    int hc;    // frames dwelt at the end
    int pulse;
  } mdl_t;

  mdl_t m;

  function automatic int max_of(input int len);
    return (len > 8) ? len - 8 : 0;
  endfunction

  function automatic mdl_t next_model(input mdl_t c);
    mdl_t n;
    int mx;
    n = c;
    n.pulse = 0;
    mx = max_of(int'(msg_len));
    if (!en) begin n.st = 0; n.fc = 0; n.hc = 0; return n; end
    if (c.st == 0) begin n.st = 1; n.dir = int'(dir); n.fc = 0; return n; end
    if (!frame_sync) return n;
    if (c.idx > mx) begin n.idx = mx; return n; end
    if (c.st == 1) begin
      if (c.fc < int'(speed)) begin n.fc = c.fc + 1; return n; end
      n.fc = 0;
      if (mx == 0) return n;
      if (c.idx == (c.dir != 0 ? 0 : mx)) begin n.st = 2; n.hc = 0; end
      else n.idx = c.idx + (c.dir != 0 ? -1 : 1);
      return n;
    end
    if (mx == 0) begin n.st = 1; n.fc = 0; return n; end
    n.hc = c.hc + 1;
    if (n.hc == HF) begin
      n.st = 1; n.fc = 0; n.pulse = 1;
      if (mode) begin
        n.dir = (c.dir != 0) ? 0 : 1;
        n.idx = (c.dir != 0) ? 1 : mx - 1;
      end else begin
        n.idx = (c.dir != 0) ? mx : 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{idx: 0, st: 0, dir: 0, fc: 0, hc: 0, pulse: 0};
    else     m <= next_model(m);
  end

  // compare process: every cycle, away from the clock edge
  always @(posedge clk) begin
    #2;
    check("mdl_idx", int'(idx), m.idx);
    check("mdl_state", int'(state), m.st);
    check("mdl_wrap", int'(wrap_pulse), m.pulse);
    check("mdl_at_end", int'(at_end),
          (m.dir != 0) ? int'(m.idx == 0) : int'(m.idx == max_of(int'(msg_len))));
    if (track_pulse && wrap_pulse) pulse_seen++;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // two quiet cycles, then a one-cycle frame_sync; returns just after its edge
  task automatic fs(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(2);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
    end
  endtask

  initial begin
    #1;
    check("rst_idx", int'(idx), 0);
    check("rst_state", int'(state), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
    check("rst_at_end", int'(at_end), 0);
    cyc(2);
    rst = 1'b0;

    // wrap mode, every frame
    en = 1'b1;
    cyc(2);
    check("run_state", int'(state), 1);
    for (int k = 1; k <= 4; k++) begin
      fs(1);
      check("wrap_step", int'(idx), k);
    end
    check("wrap_at_end", int'(at_end), 1);
    fs(1);
    check("wrap_hold", int'(state), 2);
    check("wrap_hold_idx", int'(idx), 4);
    fs(1);
    check("wrap_hold2", int'(state), 2);
    fs(1);
    check("wrap_idx0", int'(idx), 0);
    check("wrap_pulse", int'(wrap_pulse), 1);
    check("wrap_run", int'(state), 1);
    @(negedge clk);
    check("wrap_pulse_1cyc", int'(wrap_pulse), 0);
    fs(3);
    check("wrap_again", int'(idx), 3);

    // async reset mid-run
    rst = 1'b1;
    #1;
    check("arst_idx", int'(idx), 0);
    check("arst_state", int'(state), 0);
    check("arst_wrap", int'(wrap_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);

    // bounce mode, step every 2nd frame
    mode = 1'b1;
    speed = 4'd1;
    fs(1);
    check("bnc_wait", int'(idx), 0);
    fs(7);
    check("bnc_top", int'(idx), 4);
    fs(2);
    check("bnc_hold", int'(state), 2);
    fs(2);
    check("bnc_rev_idx", int'(idx), 3);
    check("bnc_rev_pulse", int'(wrap_pulse), 1);
    fs(6);
    check("bnc_bottom", int'(idx), 0);
    check("bnc_at_end", int'(at_end), 1);
    fs(2);
    check("bnc_hold0", int'(state), 2);
    fs(2);
    check("bnc_rev2", int'(idx), 1);
    check("bnc_rev2_pulse", int'(wrap_pulse), 1);

    // freeze in IDLE, restart decreasing
    speed = 4'd0;
    fs(1);
    check("frz_pre", int'(idx), 2);
    en = 1'b0;
    cyc(1);
    check("frz_idle", int'(state), 0);
    fs(10);
    check("frz_idx", int'(idx), 2);
    dir = 1'b1;
    en = 1'b1;
    cyc(1);
    fs(1);
    check("dn_1", int'(idx), 1);
    fs(1);
    check("dn_0", int'(idx), 0);
    fs(1);
    check("dn_hold", int'(state), 2);

    // shrink message while at idx=4
    en = 1'b0;
    cyc(1);
    dir = 1'b0;
    en = 1'b1;
    cyc(1);
    fs(4);
    check("shr_pre", int'(idx), 4);
    msg_len = 7'd10;
    fs(1);
    check("shr_clamp", int'(idx), 2);
    cyc(50);
    check("quiet_idx", int'(idx), 2);
    check("quiet_state", int'(state), 1);

    // short messages: nothing scrolls
    track_pulse = 1;
    msg_len = 7'd8;
    fs(1);
    check("short_clamp", int'(idx), 0);
    fs(5);
    check("short8_idx", int'(idx), 0);
    check("short8_state", int'(state), 1);
    check("short8_at_end", int'(at_end), 1);
    msg_len = 7'd5;
    fs(5);
    check("short5_idx", int'(idx), 0);
    check("short_no_pulse", pulse_seen, 0);
    track_pulse = 0;

    // speed lowered below the running frame count
    msg_len = 7'd12;
    speed = 4'd3;
    fs(2);
    check("spd_wait", int'(idx), 0);
    speed = 4'd1;
    fs(1);
    check("spd_step", int'(idx), 1);

    // mode switched mid-HOLD: bounce -> wrap decides at completion
    speed = 4'd0;
    fs(3);
    fs(1);
    check("mch_hold", int'(state), 2);
    mode = 1'b0;
    fs(2);
    check("mch_wrap_idx", int'(idx), 0);
    check("mch_wrap_pulse", int'(wrap_pulse), 1);

    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
